// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//   APB4 initiator: turns one single-beat host command at a time into an APB
//   SETUP/ACCESS transfer and holds the response (read data + slave error)
//   until the host consumes it.
//
// Optional build macro: APB_CMD_MASTER_TIMEOUT_EN
//   Adds an ACCESS wait-state counter. A transfer that sees TIMEOUT_CYCLES
//   consecutive pready=0 cycles is aborted and answered with rsp_err=1,
//   rsp_rdata=0. Without the macro ACCESS waits for pready indefinitely.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       host command handshake (cmd_ready registered)
//   cmd_write/addr/wdata/strb command payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_err        captured prdata (0 for writes) and error
//   psel/penable/pwrite       APB control
//   paddr/pwdata/pstrb        APB address, write data, strobes
//   prdata/pready/pslverr     APB slave response
// ---------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [DATA_W/8-1:0]   pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = S_SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          // Reads drive zero data and strobes on the bus.
          pwdata_d = cmd_write ? cmd_wdata : '0;
          pstrb_d  = cmd_write ? cmd_strb  : '0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_ACCESS: begin
        if (pready) begin
          state_d     = S_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This cycle is the TIMEOUT_CYCLES-th wait state: give up.
          state_d     = S_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered ready: high exactly while the FSM sits in IDLE, so it is
    // still low in the first cycle after reset release.
    cmd_ready_d = (state_d == S_IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [3:0]        cmd_strb;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;
  logic [3:0]        pstrb;
  logic              pready, pslverr;

  int checks = 0;
  int errors = 0;

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Bounded wait (at negedges) for cmd_ready.
  task automatic wait_cmd_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 0; prdata = '0; pready = 0; pslverr = 0;
    #3;
    checks++; if ({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err} !== 6'b0) begin errors++; $display("FAIL rst_ctrl: got %b, expected 000000", {psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err}); end
    checks++; if ({paddr, pwdata, pstrb, rsp_rdata} !== '0) begin errors++; $display("FAIL rst_data: got %h %h %h %h, expected all 0", paddr, pwdata, pstrb, rsp_rdata); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_rdy_first: got %b, expected 0", cmd_ready); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_rdy_after: got %b, expected 1", cmd_ready); end
    // Reset in the middle of ACCESS.
    wait_cmd_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_wait_ready: timed out, expected cmd_ready"); end
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h01C; pready = 0;
    @(negedge clk); cmd_valid = 0;
    @(negedge clk);
    checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL rst_in_access: got %b, expected 11", {psel, penable}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({psel, penable, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid_drop: got %b, expected 000", {psel, penable, rsp_valid}); end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if ({cmd_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL rst_mid_release: got %b, expected 00", {cmd_ready, rsp_valid}); end
    @(negedge clk);
    checks++; if ({cmd_ready, rsp_valid, psel} !== 3'b100) begin errors++; $display("FAIL rst_mid_idle: got %b, expected 100", {cmd_ready, rsp_valid, psel}); end
  endtask

  task automatic test_read_wait();
    bit ok;
    int pen_cnt;
    wait_cmd_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_wait_ready: timed out, expected cmd_ready"); end
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h010; cmd_wdata = 32'hDEAD_BEEF; cmd_strb = 4'hF;
    pready = 0; prdata = 32'h1234_5678;
    @(negedge clk); cmd_valid = 0;
    checks++; if ({psel, penable, pwrite} !== 3'b100) begin errors++; $display("FAIL rd_setup_ctrl: got %b, expected 100", {psel, penable, pwrite}); end
    checks++; if (paddr !== 12'h010 || pstrb !== 4'h0 || pwdata !== 32'h0) begin errors++; $display("FAIL rd_setup_bus: got %h %h %h, expected 010 0 00000000", paddr, pstrb, pwdata); end
    pen_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (penable === 1'b1 && psel === 1'b1) pen_cnt++;
      if (i == 3) begin pready = 1; prdata = 32'hFFFF_FFFF; end
    end
    checks++; if (pen_cnt != 4) begin errors++; $display("FAIL rd_penable_cycles: got %0d, expected 4", pen_cnt); end
    @(negedge clk); pready = 0;
    checks++; if ({psel, penable, rsp_valid, rsp_err} !== 4'b0010) begin errors++; $display("FAIL rd_resp_ctrl: got %b, expected 0010", {psel, penable, rsp_valid, rsp_err}); end
    checks++; if (rsp_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rd_rdata: got %h, expected ffffffff", rsp_rdata); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL rd_consume: got %b, expected 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_write();
    bit ok;
    wait_cmd_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_wait_ready: timed out, expected cmd_ready"); end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h00C; cmd_wdata = 32'h0000_1234; cmd_strb = 4'hF;
    pready = 1; pslverr = 0; prdata = 32'hCAFE_F00D;
    @(negedge clk); cmd_valid = 0;
    checks++; if ({psel, penable, pwrite, cmd_ready} !== 4'b1010) begin errors++; $display("FAIL wr_setup_ctrl: got %b, expected 1010", {psel, penable, pwrite, cmd_ready}); end
    checks++; if (paddr !== 12'h00C || pwdata !== 32'h1234 || pstrb !== 4'hF) begin errors++; $display("FAIL wr_setup_bus: got %h %h %h, expected 00c 00001234 f", paddr, pwdata, pstrb); end
    @(negedge clk);
    checks++; if ({psel, penable} !== 2'b11 || paddr !== 12'h00C || pwdata !== 32'h1234) begin errors++; $display("FAIL wr_access: got %b %h %h, expected 11 00c 00001234", {psel, penable}, paddr, pwdata); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_err, psel, penable} !== 4'b1000) begin errors++; $display("FAIL wr_resp_ctrl: got %b, expected 1000", {rsp_valid, rsp_err, psel, penable}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata_zero: got %h, expected 00000000", rsp_rdata); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0; pready = 0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01 || paddr !== 12'h00C || pwdata !== 32'h1234) begin errors++; $display("FAIL wr_idle_hold: got %b %h %h, expected 01 00c 00001234", {rsp_valid, cmd_ready}, paddr, pwdata); end
  endtask

  task automatic test_slave_err();
    bit ok;
    wait_cmd_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_wait_ready: timed out, expected cmd_ready"); end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h000; cmd_wdata = 32'h0000_0F00; cmd_strb = 4'h2;
    pready = 1; pslverr = 1;
    @(negedge clk);
    // Keep cmd_valid high with the next command already presented.
    cmd_addr = 12'h004; cmd_wdata = 32'h0000_00AA; cmd_strb = 4'h1;
    checks++; if (paddr !== 12'h000 || pwdata !== 32'h0F00 || pstrb !== 4'h2) begin errors++; $display("FAIL err_setup_bus: got %h %h %h, expected 000 00000f00 2", paddr, pwdata, pstrb); end
    @(negedge clk);
    @(negedge clk); pslverr = 0;
    checks++; if ({rsp_valid, rsp_err} !== 2'b11) begin errors++; $display("FAIL err_rsp: got %b, expected 11", {rsp_valid, rsp_err}); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({cmd_ready, psel, rsp_valid} !== 3'b001) begin errors++; $display("FAIL err_blocked: got %b, expected 001", {cmd_ready, psel, rsp_valid}); end
    end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    checks++; if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin errors++; $display("FAIL err_after_consume: got %b, expected 100", {cmd_ready, psel, rsp_valid}); end
    @(negedge clk); cmd_valid = 0;
    pslverr = 1; // SETUP phase: must be ignored
    checks++; if (psel !== 1'b1 || paddr !== 12'h004 || pstrb !== 4'h1) begin errors++; $display("FAIL err_next_accept: got %b %h %h, expected 1 004 1", psel, paddr, pstrb); end
    @(negedge clk); pslverr = 0;
    @(negedge clk); pready = 0;
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("FAIL err_pslverr_setup_ignored: got %b, expected 10", {rsp_valid, rsp_err}); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_cmd_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_wait_ready: timed out, expected cmd_ready"); end
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h008; pready = 1; pslverr = 1; prdata = 32'hA5A5_0001;
    @(negedge clk);
    cmd_write = 1; cmd_addr = 12'h018; cmd_wdata = 32'h0000_5555; cmd_strb = 4'h3;
    @(negedge clk);
    @(negedge clk);
    prdata = 32'h0; pslverr = 0; pready = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, rsp_err, cmd_ready, psel} !== 4'b1100 || rsp_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL bp_hold%0d: got %b %h, expected 1100 a5a50001", i, {rsp_valid, rsp_err, cmd_ready, psel}, rsp_rdata); end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    checks++; if ({cmd_ready, psel} !== 2'b10) begin errors++; $display("FAIL b2b_ready: got %b, expected 10", {cmd_ready, psel}); end
    @(negedge clk); cmd_valid = 0; pready = 1;
    checks++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 12'h018 || pwrite !== 1'b1) begin errors++; $display("FAIL b2b_setup: got %b%b %h %b, expected 10 018 1", psel, penable, paddr, pwrite); end
    @(negedge clk);
    @(negedge clk); pready = 0;
    checks++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_resp: got %b %h, expected 10 00000000", {rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
  endtask

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int pen_cnt;
    wait_cmd_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_wait_ready: timed out, expected cmd_ready"); end
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h014; pready = 0; pslverr = 0; prdata = 32'h7777_7777;
    @(negedge clk); cmd_valid = 0;
    pen_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (penable === 1'b1) pen_cnt++;
    end
    checks++; if (pen_cnt != 4) begin errors++; $display("FAIL to_wait_cycles: got %0d, expected 4", pen_cnt); end
    @(negedge clk);
    checks++; if ({psel, penable, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_abort: got %b %h, expected 0011 00000000", {psel, penable, rsp_valid, rsp_err}, rsp_rdata); end
    pready = 1; prdata = 32'h5555_5555;
    @(negedge clk); pready = 0;
    checks++; if ({psel, penable, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_late_pready: got %b %h, expected 0011 00000000", {psel, penable, rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_read_wait();
    test_write();
    test_slave_err();
    test_back_to_back();
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
